// File: rtl/hsiao_ecc_dec_wrap_pipe.sv
// ============================================================================
// Module   : hsiao_ecc_dec_wrap_pipe (plus leaf hsiao_ecc_dec)
// Purpose  : Read-side ECC wrapper for the cache data/tag SRAMs. It decodes
//            ASSOC ways in parallel. Each way is a SIZE_ECC-bit word made of
//            DIVISIONS Hsiao SECDED codewords. The decoded data and per-way
//            error flags go out through one registered valid/ready stage.
//            The block also keeps a sticky fatal flag and optional error
//            counters.
// Code     : Each block codeword is {check[R-1:0], data[K-1:0]}.
//            - The check bits are the unit columns of H.
//            - Data bit j uses the j-th odd-weight (>=3) R-bit vector, taking
//              these vectors in ascending numeric order.
//            - Even-weight (>=2) vectors are used only when there are not
//              enough odd-weight ones (tiny K).
// Ports    : clk_i, rst_ni (async, active low)
//            valid_i/ready_o/data_i   - codeword beat in
//            valid_o/ready_i/data_o   - corrected beat out
//            single_err_o/double_err_o - per-way flags, qualified by valid_o
//            fatal_o, clear_i          - sticky uncorrectable flag and its clear
//            cnt_single_o/cnt_double_o - saturating beat counters
// Config   : HSIAO_DEC_ERR_CNT_EN enables the counters. When it is undefined,
//            both counter outputs read 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsiao_ecc_dec #(
    parameter int K = 32,
    parameter int R = 7
) (
    input  logic [K+R-1:0] cw_i,
    output logic [K-1:0]   data_o,
    output logic [1:0]     err_o
);

    function automatic logic [R-1:0] col_of(input int idx);
        logic [R-1:0] v;
        int           n;
        int           w;
        col_of = '0;
        n      = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int x = 1; x < (1 << R); x++) begin
                v = x[R-1:0];
                w = $countones(v);
                if ((pass == 0 && w[0] && w >= 3) || (pass == 1 && !w[0] && w >= 2)) begin
                    if (n == idx) col_of = v;
                    n++;
                end
            end
        end
    endfunction

    logic [R-1:0] w_cols [K];
    logic [R-1:0] w_syn;
    logic [R-1:0] w_unit;
    logic         w_hit;

    for (genvar j = 0; j < K; j++) begin : g_col
        localparam logic [R-1:0] COL = col_of(j);
        assign w_cols[j] = COL;
    end

    always_comb begin
        w_syn  = cw_i[K+R-1:K];
        data_o = cw_i[K-1:0];
        w_hit  = 1'b0;
        w_unit = '0;
        for (int j = 0; j < K; j++) begin
            if (cw_i[j]) w_syn = w_syn ^ w_cols[j];
        end
        for (int j = 0; j < K; j++) begin
            if (w_syn == w_cols[j]) begin
                data_o[j] = ~cw_i[j];
                w_hit     = 1'b1;
            end
        end
        // A syndrome equal to a unit vector is a flipped check bit.
        // The data is already correct in that case.
        for (int p = 0; p < R; p++) begin
            w_unit    = '0;
            w_unit[p] = 1'b1;
            if (w_syn == w_unit) w_hit = 1'b1;
        end
        err_o[0] = w_hit;
        err_o[1] = (w_syn != '0) && !w_hit;
    end

endmodule

module hsiao_ecc_dec_wrap_pipe #(
    parameter int DIVISIONS = 1,
    parameter int ASSOC     = 1,
    parameter int SIZE      = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                                            clk_i,
    input  logic                                                            rst_ni,
    input  logic                                                            valid_i,
    output logic                                                            ready_o,
    input  logic [ASSOC-1:0][(SIZE/DIVISIONS+$clog2(SIZE/DIVISIONS)+2)*DIVISIONS-1:0] data_i,
    output logic                                                            valid_o,
    input  logic                                                            ready_i,
    output logic [ASSOC-1:0][SIZE-1:0]                                      data_o,
    output logic [ASSOC-1:0]                                                single_err_o,
    output logic [ASSOC-1:0]                                                double_err_o,
    output logic                                                            fatal_o,
    input  logic                                                            clear_i,
    output logic [CNT_WIDTH-1:0]                                            cnt_single_o,
    output logic [CNT_WIDTH-1:0]                                            cnt_double_o
);

    localparam int BLOCK_SIZE     = SIZE / DIVISIONS;
    localparam int PAR_BITS       = $clog2(BLOCK_SIZE) + 2;
    localparam int BLOCK_SIZE_ECC = BLOCK_SIZE + PAR_BITS;

    logic [ASSOC-1:0][SIZE-1:0] w_dec_data;
    logic [ASSOC-1:0]           w_single;
    logic [ASSOC-1:0]           w_double;
    logic                       w_accept;

    logic                       valid_q;
    logic [ASSOC-1:0][SIZE-1:0] data_q;
    logic [ASSOC-1:0]           single_q;
    logic [ASSOC-1:0]           double_q;
    logic                       fatal_q;
    logic                       fatal_d;

    for (genvar i = 0; i < ASSOC; i++) begin : g_way
        logic [DIVISIONS-1:0] w_e0;
        logic [DIVISIONS-1:0] w_e1;
        for (genvar j = 0; j < DIVISIONS; j++) begin : g_blk
            logic [1:0] w_err;
            hsiao_ecc_dec #(
                .K (BLOCK_SIZE),
                .R (PAR_BITS)
            ) u_dec (
                .cw_i   (data_i[i][j*BLOCK_SIZE_ECC +: BLOCK_SIZE_ECC]),
                .data_o (w_dec_data[i][j*BLOCK_SIZE +: BLOCK_SIZE]),
                .err_o  (w_err)
            );
            assign w_e0[j] = w_err[0];
            assign w_e1[j] = w_err[1];
        end
        assign w_single[i] = |w_e0;
        assign w_double[i] = |w_e1;
    end

    // A single output register. Ready stays high whenever the register is
    // empty or draining this cycle, so a full-rate stream moves with no
    // bubble.
    assign ready_o  = !valid_q || ready_i;
    assign w_accept = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            single_q <= '0;
            double_q <= '0;
        end else if (w_accept) begin
            valid_q  <= 1'b1;
            data_q   <= w_dec_data;
            single_q <= w_single;
            double_q <= w_double;
        end else if (ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    // If clear and a new error arrive in the same cycle, clear wins and the
    // error event is dropped.
    always_comb begin
        fatal_d = fatal_q;
        if (clear_i) begin
            fatal_d = 1'b0;
        end else if (w_accept && |w_double) begin
            fatal_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fatal_q <= 1'b0;
        end else begin
            fatal_q <= fatal_d;
        end
    end

`ifdef HSIAO_DEC_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_single_q;
    logic [CNT_WIDTH-1:0] cnt_double_q;
    logic [CNT_WIDTH-1:0] cnt_single_d;
    logic [CNT_WIDTH-1:0] cnt_double_d;

    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (clear_i) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (w_accept) begin
            if (|w_single && cnt_single_q != '1) cnt_single_d = cnt_single_q + 1'b1;
            if (|w_double && cnt_double_q != '1) cnt_double_d = cnt_double_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign cnt_single_o = cnt_single_q;
    assign cnt_double_o = cnt_double_q;
`else
    assign cnt_single_o = '0;
    assign cnt_double_o = '0;
`endif

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign single_err_o = single_q;
    assign double_err_o = double_q;
    assign fatal_o      = fatal_q;

endmodule

`default_nettype wire

// File: tb/tb_hsiao_ecc_dec_wrap_pipe.sv
// ============================================================================
// Module   : tb_hsiao_ecc_dec_wrap_pipe
// Purpose  : Scoreboard bench for hsiao_ecc_dec_wrap_pipe.
//            Configuration: SIZE=64, DIVISIONS=2, ASSOC=2, CNT_WIDTH=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsiao_ecc_dec_wrap_pipe;

    localparam int SIZE = 64;
    localparam int DIV  = 2;
    localparam int WAYS = 2;
    localparam int CW   = 2;
    localparam int BS   = 32;
    localparam int BSE  = 39;
    localparam int SE   = 78;

    typedef struct {
        logic [WAYS-1:0][SIZE-1:0] d;
        logic [WAYS-1:0]           s;
        logic [WAYS-1:0]           db;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       valid_i = 1'b0;
    logic                       ready_o;
    logic [WAYS-1:0][SE-1:0]    data_i = '0;
    logic                       valid_o;
    logic                       ready_i = 1'b1;
    logic [WAYS-1:0][SIZE-1:0]  data_o;
    logic [WAYS-1:0]            single_err_o;
    logic [WAYS-1:0]            double_err_o;
    logic                       fatal_o;
    logic                       clear_i = 1'b0;
    logic [CW-1:0]              cnt_single_o;
    logic [CW-1:0]              cnt_double_o;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t drv_exp;
    logic [6:0] cols [BS];

    logic                      exp_fatal = 1'b0;
    logic [CW-1:0]             exp_cs = '0;
    logic [CW-1:0]             exp_cd = '0;
    logic                      stall_q = 1'b0;
    logic [WAYS-1:0][SIZE-1:0] stall_data;
    logic [WAYS-1:0]           stall_s;
    logic [WAYS-1:0]           stall_db;

    always #5 clk = ~clk;

    hsiao_ecc_dec_wrap_pipe #(
        .DIVISIONS (DIV),
        .ASSOC     (WAYS),
        .SIZE      (SIZE),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .single_err_o (single_err_o),
        .double_err_o (double_err_o),
        .fatal_o      (fatal_o),
        .clear_i      (clear_i),
        .cnt_single_o (cnt_single_o),
        .cnt_double_o (cnt_double_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BSE-1:0] enc(input logic [BS-1:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < BS; j++) if (d[j]) p = p ^ cols[j];
        return {p, d};
    endfunction

    function automatic logic [BSE-1:0] mk_flip(input int mode);
        logic [BSE-1:0] f;
        int a, b;
        f = '0;
        a = $urandom_range(BSE-1);
        b = (a + 1 + $urandom_range(BSE-2)) % BSE;
        if (mode >= 1) f[a] = 1'b1;
        if (mode >= 2) f[b] = 1'b1;
        return f;
    endfunction

    // Encode both ways, apply the flip masks, and derive the expected output:
    // - 0 or 1 flipped bits in a block: the original data comes back.
    // - 2 flipped bits: the raw (uncorrected) data comes back.
    task automatic send(input logic [WAYS-1:0][SIZE-1:0] d, input logic [WAYS-1:0][SE-1:0] flip);
        int   cyc;
        int   n;
        exp_t e;
        for (int i = 0; i < WAYS; i++) begin
            e.s[i]  = 1'b0;
            e.db[i] = 1'b0;
            for (int b = 0; b < DIV; b++) begin
                data_i[i][b*BSE +: BSE] = enc(d[i][b*BS +: BS]) ^ flip[i][b*BSE +: BSE];
                n = $countones(flip[i][b*BSE +: BSE]);
                e.d[i][b*BS +: BS] = (n >= 2) ? (d[i][b*BS +: BS] ^ flip[i][b*BSE +: BS]) : d[i][b*BS +: BS];
                if (n == 1) e.s[i] = 1'b1;
                if (n >= 2) e.db[i] = 1'b1;
            end
        end
        drv_exp = e;
        valid_i = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!ready_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready_o) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Scoreboard monitor and reference model. Inputs change only just after
    // posedge, so sampling at negedge sees stable values.
    always @(negedge clk) begin
        exp_t e;
        logic acc;
        if (!rst_ni) begin
            q.delete();
            exp_fatal = 1'b0;
            exp_cs    = '0;
            exp_cd    = '0;
            stall_q   = 1'b0;
        end else begin
            check("fatal", fatal_o, exp_fatal);
`ifdef HSIAO_DEC_ERR_CNT_EN
            check("cnt_single", cnt_single_o, exp_cs);
            check("cnt_double", cnt_double_o, exp_cd);
`else
            check("cnt_single_tied", cnt_single_o, 0);
            check("cnt_double_tied", cnt_double_o, 0);
`endif
            if (stall_q) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, stall_data);
                check("stall_flags", {single_err_o, double_err_o}, {stall_s, stall_db});
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("data", data_o, e.d);
                    check("single_err", single_err_o, e.s);
                    check("double_err", double_err_o, e.db);
                end
            end
            stall_q    = valid_o && !ready_i;
            stall_data = data_o;
            stall_s    = single_err_o;
            stall_db   = double_err_o;
            acc = valid_i && ready_o;
            if (acc) q.push_back(drv_exp);
            if (clear_i) begin
                exp_fatal = 1'b0;
                exp_cs    = '0;
                exp_cd    = '0;
            end else if (acc) begin
                if (|drv_exp.db) exp_fatal = 1'b1;
                if (|drv_exp.s && exp_cs != '1) exp_cs = exp_cs + 1'b1;
                if (|drv_exp.db && exp_cd != '1) exp_cd = exp_cd + 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WAYS-1:0][SIZE-1:0] d;
        logic [WAYS-1:0][SE-1:0]   f;
        int n;
        int cyc;

        // Data bit j uses the j-th odd-weight (>=3) 7-bit column, in ascending
        // numeric order.
        n = 0;
        for (int x = 1; x < 128; x++) begin
            if (n < BS && ($countones(x) % 2 == 1) && $countones(x) >= 3) begin
                cols[n] = x[6:0];
                n++;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_flags", {single_err_o, double_err_o}, 0);
        check("rst_fatal", fatal_o, 0);
        check("rst_cnt", {cnt_single_o, cnt_double_o}, 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Clean beat.
        d = {64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567};
        send(d, '0);
        check("clean_valid", valid_o, 1);
        check("clean_data", data_o, d);

        // Single-bit error: bit 5 of way 1, block 1.
        f = '0;
        f[1][BSE + 5] = 1'b1;
        send(d, f);
        check("single_flag", single_err_o, 2'b10);
        check("single_data", data_o, d);

        // Double-bit error: bits 3 and 17 of way 0, block 0. The fatal flag
        // is sticky.
        f = '0;
        f[0][3]  = 1'b1;
        f[0][17] = 1'b1;
        send(d, f);
        check("double_flag", double_err_o, 2'b01);
        check("fatal_set", fatal_o, 1);
        send({64'h1, 64'h2}, '0);
        send({64'h3, 64'h4}, '0);
        check("fatal_sticky", fatal_o, 1);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("fatal_clear", fatal_o, 0);

        // A clear in the same cycle as an accepted double error wins.
        clear_i = 1'b1;
        send(d, f);
        clear_i = 1'b0;
        check("clear_wins", fatal_o, 0);

        // Four back-to-back beats, with ready_i low for 3 cycles mid-stream.
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join_none
        for (int k = 0; k < 4; k++) begin
            d = {{$urandom, $urandom}, {$urandom, $urandom}};
            send(d, '0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Five single-error beats saturate a 2-bit counter; then clear it.
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = '0;
            f[k % 2][$urandom_range(SE-1)] = 1'b1;
            send({{$urandom, $urandom}, {$urandom, $urandom}}, f);
        end
`ifdef HSIAO_DEC_ERR_CNT_EN
        check("cnt_sat", cnt_single_o, 3);
`else
        check("cnt_off", cnt_single_o, 0);
`endif
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("cnt_cleared", cnt_single_o, 0);

        // Mixed random traffic with random backpressure.
        fork
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(3) != 0);
                end
                ready_i = 1'b1;
            end
        join_none
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < WAYS; i++)
                for (int b = 0; b < DIV; b++)
                    f[i][b*BSE +: BSE] = mk_flip($urandom_range(2));
            send({{$urandom, $urandom}, {$urandom, $urandom}}, f);
        end
        repeat (70) @(posedge clk);
        #1;
        ready_i = 1'b1;

        // Asynchronous reset while a double-error beat is stalled.
        f = '0;
        f[1][40] = 1'b1;
        f[1][60] = 1'b1;
        ready_i = 1'b0;
        send(d, f);
        @(negedge clk);
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_fatal", fatal_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_data", data_o, 0);
        check("arst_flags", {single_err_o, double_err_o}, 0);
        check("arst_fatal", fatal_o, 0);
        check("arst_cnt", {cnt_single_o, cnt_double_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_beat", valid_o, 0);

        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
